// File: rtl/uap_pkg.sv
// Shared constants and state encoding for the demodulator packet path.
package uap_pkg;

  localparam int REFERENCE_LENGTH = 15;
  localparam int PACKET_LEN       = 224;
  localparam int BUF_DEPTH        = 256;
  localparam int ADDR_W           = 8;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } pkt_buf_state_t;

endpackage

// File: rtl/bit_ring_ram.sv
// DEPTH x 1 flop ring. One write port and one combinational read port; 0-cycle read.
// Write-to-read bypass: a read of the address being written returns the new bit.
module bit_ring_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/demod_packet_buffer.sv
// Captures one demod bit per symbol strobe into a ring, then drains PACKET_LEN bits from start_addr.
// done at T gives out_valid at T+1; 1 bit/cycle; out_bit/out_last held while out_ready is low.
module demod_packet_buffer
  import uap_pkg::*;
#(
  parameter int BUF_DEPTH  = uap_pkg::BUF_DEPTH,
  parameter int ADDR_W     = uap_pkg::ADDR_W,
  parameter int PACKET_LEN = uap_pkg::PACKET_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              demod_enable,
  input  logic              sym_strobe,
  input  logic              demod_bit,
  input  logic              done,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(PACKET_LEN - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(BUF_DEPTH);

  pkt_buf_state_t state, state_nxt;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W:0]   wr_cnt;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic              start_cap;
  logic              load_first;
  logic              advance;
  logic              finish;
  logic              handshake;

  assign handshake = out_valid & out_ready;

  bit_ring_ram #(
    .DEPTH (BUF_DEPTH),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (demod_bit),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_cap  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr;
    rd_addr    = rd_ptr + 1'b1;
    load_first = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (demod_enable) begin
          start_cap = 1'b1;
          wr_en     = sym_strobe;
          wr_addr   = '0;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        // Enable drop is ignored here: the synchronizer releases it in the done cycle.
        wr_en = sym_strobe;
        if (done) begin
          load_first = 1'b1;
          rd_addr    = start_addr;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        if (handshake) begin
          if (rd_cnt == LAST_CNT) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (start_cap) begin
        wr_ptr   <= {{(ADDR_W-1){1'b0}}, sym_strobe};
        wr_cnt   <= {{ADDR_W{1'b0}}, sym_strobe};
        overflow <= 1'b0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        // Count saturates at full; any strobe beyond it is an overrun.
        if (wr_cnt == FULL_CNT) overflow <= 1'b1;
        else                    wr_cnt   <= wr_cnt + 1'b1;
      end

      if (load_first) begin
        rd_ptr    <= start_addr;
        rd_cnt    <= '0;
        out_bit   <= rd_data;
        out_valid <= 1'b1;
      end else if (advance) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_cnt  <= rd_cnt + 1'b1;
        out_bit <= rd_data;
      end else if (finish) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_last = out_valid && (rd_cnt == LAST_CNT);
  assign busy     = (state != IDLE);

endmodule

// File: doc/demod_packet_buffer.md
Name: demod_packet_buffer

Overview:
- Downstream of the bit synchronizer. Captures one demodulated bit per symbol strobe into a circular 1-bit buffer.
- When the synchronizer signals packet completion, it supplies the packet start address. The block then drains PACKET_LEN bits from that address over a valid/ready stream to the packet decoder.
- Single clock domain. The symbol clock is taken as a one-cycle strobe in the clk domain.

Parameters:
- BUF_DEPTH, 256: buffer entries. Must be a power of 2.
- ADDR_W, 8: pointer width, equal to log2(BUF_DEPTH).
- PACKET_LEN, 224: bits emitted per packet. Range is 1..BUF_DEPTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- demod_enable  in  1  high while the demodulator is running
- sym_strobe  in  1  one-cycle pulse per demodulated symbol
- demod_bit  in  1  demodulated bit, valid when sym_strobe=1
- done  in  1  one-cycle pulse: packet capture complete
- start_addr  in  ADDR_W  buffer index of the first packet bit, sampled when done=1
- out_bit  out  1  packet bit
- out_valid  out  1  out_bit valid
- out_ready  in  1  consumer accepts the bit
- out_last  out  1  marks the final bit of the packet
- busy  out  1  high when state is not IDLE
- overflow  out  1  sticky; more than BUF_DEPTH strobes were seen in one capture

Behaviour:
- Reset, at the clk edge with rst=1:
  - state=IDLE, wr_ptr=0, rd_ptr=0, rd_cnt=0.
  - out_valid=0, out_last=0, out_bit=0, busy=0, overflow=0.
  - Buffer contents are don't-care.
  - rst overrides all other inputs in the same cycle, including mid-capture and mid-drain.
- State machine, three states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - demod_enable=1 → CAPTURE, with wr_ptr←0 and overflow←0.
  - If sym_strobe=1 in that same cycle, it is written to entry 0 and wr_ptr←1.
  - done is ignored.
- CAPTURE:
  - sym_strobe=1 → buf[wr_ptr]←demod_bit, wr_ptr←wr_ptr+1 mod BUF_DEPTH.
  - A wr_cnt of width ADDR_W+1 counts strobes. The strobe that takes wr_cnt past BUF_DEPTH sets overflow. Writes continue and wrap, overwriting the oldest entries.
  - demod_enable falling is ignored; only done ends capture, because the synchronizer drops enable in the completion cycle.
- CAPTURE with done=1:
  - A coincident sym_strobe is written first.
  - Then rd_ptr←start_addr, rd_cnt←0, → DRAIN.
  - The output register loads buf[start_addr], with bypass if it equals the address being written that cycle. out_valid=1 from the next cycle.
  - Latency: done at cycle T gives out_valid=1 at T+1.
- DRAIN:
  - out_valid stays high until handshake (out_valid & out_ready). out_bit is stable while stalled.
  - On handshake with rd_cnt<PACKET_LEN-1: rd_ptr←rd_ptr+1 mod BUF_DEPTH, rd_cnt++, out_bit←buf[rd_ptr+1] in the same cycle.
  - Throughput is 1 bit per cycle.
  - out_last=1 exactly when rd_cnt=PACKET_LEN-1 and out_valid=1.
  - Handshake on the last bit → IDLE with out_valid=0 and out_last=0 the next cycle.
  - sym_strobe, done and demod_enable are ignored in DRAIN.
- Read wrap: rd_ptr wraps from BUF_DEPTH-1 to 0.
- start_addr is trusted; no range check beyond the modulo.
- busy is 1 in CAPTURE and DRAIN.
- overflow holds its value through DRAIN and IDLE. It clears only on rst or on the next IDLE→CAPTURE entry.
- Storage: BUF_DEPTH×1 flop array with combinational read into the registered out_bit. No block RAM is required.

Decomposition:
- Shared package uap_pkg holds:
  - constants REFERENCE_LENGTH=15, PACKET_LEN=224, BUF_DEPTH=256, ADDR_W=8;
  - the state enum typedef pkt_buf_state_t {IDLE, CAPTURE, DRAIN}.
- One natural sub-module: bit_ring_ram. It is a BUF_DEPTH×1 array with a write port (we, waddr, wdata) and a combinational read port (raddr, rdata), including write-to-read bypass.
- The FSM, pointers and output register stay in demod_packet_buffer.

Test Plan:
- Basic packet:
  - Stimulus: enable, 239 strobes with bits = LSB of the strobe index, then done with start_addr=15, out_ready=1.
  - Response: out_valid at T+1; 224 bits equal to buf[15..238]; out_last on the 224th bit only; busy=0 after.
- Wrap-around:
  - Stimulus: 256 strobes, done with start_addr=200.
  - Response: bits from entries 200..255 then 0..167; overflow=0.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1 during drain.
  - Response: out_bit and out_last are held during stall cycles; no bit is lost or duplicated; the total is 224.
- Coincident events:
  - Stimulus: sym_strobe and done in the same cycle with start_addr = that write address.
  - Response: the first out_bit equals the just-written demod_bit.
- Overflow:
  - Stimulus: 260 strobes.
  - Response: overflow=1 after the 257th strobe; it stays 1 through drain; it clears on the next enable.
- Reset mid-drain:
  - Stimulus: assert rst after 50 handshakes.
  - Response: next cycle out_valid=0, busy=0; the next capture starts at wr_ptr=0.
